// File: rtl/nmos_dff_shreg_pkg.sv
// Shared constants and helpers for the two-phase master/slave shift register.
// Holds the stage packing helper and the constant clog2 used to size decay counters.
package nmos_dff_shreg_pkg;

   // Lowest bit of stage idx inside a packed WIDTH*DEPTH bus.
   function automatic int stage_lo(input int idx, input int width);
      return idx * width;
   endfunction

   // Ceiling log2, with a floor of 0, evaluated at elaboration.
   function automatic int clog2(input int value);
      int r;
      int v;
      r = 0;
      v = value - 1;
      while (v > 0) begin
         r++;
         v = v >> 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/nmos_dff_stage.sv
// One master/slave pair. C2 writes the master and C1 copies it to the slave.
// An optional counter lets an unrefreshed slave decay to DECAY_VAL.
module nmos_dff_stage
   import nmos_dff_shreg_pkg::*;
#(
   parameter int   WIDTH     = 1,
   parameter int   DECAY_CYC = 0,
   parameter logic DECAY_VAL = 1'b0
) (
   input  logic             main_clk,
   input  logic             R_n,
   input  logic             c1,
   input  logic             c2,
   input  logic             ld,
   input  logic             sh,
   input  logic [WIDTH-1:0] shift_in,
   input  logic [WIDTH-1:0] p,
   output logic [WIDTH-1:0] slave,
   output logic             stale
);

   localparam logic [WIDTH-1:0] DECAY_WORD = {WIDTH{DECAY_VAL}};

   logic [WIDTH-1:0] master;
   logic             decay_hit;

   // Non-blocking updates keep master and slave on pre-edge values when C1 and C2 overlap.
   always_ff @(posedge main_clk or negedge R_n) begin
      if (!R_n) begin
         master <= '0;
         slave  <= '0;
      end else begin
         if (c2) begin
            if (ld)      master <= p;
            else if (sh) master <= shift_in;
            else         master <= slave;
         end
         if (c1)             slave <= master;
         else if (decay_hit) slave <= DECAY_WORD;
      end
   end

   generate
      if (DECAY_CYC > 0) begin : g_decay
         localparam int            CW   = clog2(DECAY_CYC + 1);
         localparam logic [CW-1:0] CMAX = CW'(DECAY_CYC);
         localparam logic [CW-1:0] CHIT = CW'(DECAY_CYC - 1);

         logic [CW-1:0] cnt;
         logic          stale_r;

         // Fires only on the edge where the count steps onto DECAY_CYC, not while saturated.
         assign decay_hit = !c1 && (cnt == CHIT);
         assign stale     = stale_r;

         always_ff @(posedge main_clk or negedge R_n) begin
            if (!R_n) begin
               cnt     <= '0;
               stale_r <= 1'b0;
            end else if (c1) begin
               cnt     <= '0;
               stale_r <= 1'b0;
            end else begin
               if (cnt != CMAX) cnt <= cnt + CW'(1);
               if (decay_hit)   stale_r <= 1'b1;
            end
         end
      end else begin : g_no_decay
         assign decay_hit = 1'b0;
         assign stale     = 1'b0;
      end
   endgenerate

endmodule

// File: rtl/nmos_dff_shreg.sv
// Two-phase (PHI1/PHI2) shift register modelled on main_clk with per-stage decay.
// Stage 0 shifts in D; the last slave drives Q. OVL latches any C1/C2 overlap.
module nmos_dff_shreg
   import nmos_dff_shreg_pkg::*;
#(
   parameter int   WIDTH     = 1,
   parameter int   DEPTH     = 1,
   parameter int   DECAY_CYC = 0,
   parameter logic DECAY_VAL = 1'b0
) (
   input  logic                   main_clk,
   input  logic                   R_n,
   input  logic                   C1,
   input  logic                   C2,
   input  logic                   SH,
   input  logic                   LD,
   input  logic [WIDTH-1:0]       D,
   input  logic [WIDTH*DEPTH-1:0] P,
   output logic [WIDTH-1:0]       Q,
   output logic [WIDTH-1:0]       Q_n,
   output logic [WIDTH*DEPTH-1:0] PQ,
   output logic [DEPTH-1:0]       STALE,
   output logic                   OVL
);

   genvar i;
   generate
      for (i = 0; i < DEPTH; i++) begin : g_stage
         localparam int LO = stage_lo(i, WIDTH);
         logic [WIDTH-1:0] shift_in;

         if (i == 0) begin : g_head
            assign shift_in = D;
         end else begin : g_link
            assign shift_in = PQ[stage_lo(i - 1, WIDTH) +: WIDTH];
         end

         nmos_dff_stage #(
            .WIDTH     (WIDTH),
            .DECAY_CYC (DECAY_CYC),
            .DECAY_VAL (DECAY_VAL)
         ) u_stage (
            .main_clk (main_clk),
            .R_n      (R_n),
            .c1       (C1),
            .c2       (C2),
            .ld       (LD),
            .sh       (SH),
            .shift_in (shift_in),
            .p        (P[LO +: WIDTH]),
            .slave    (PQ[LO +: WIDTH]),
            .stale    (STALE[i])
         );
      end
   endgenerate

   assign Q   = PQ[stage_lo(DEPTH - 1, WIDTH) +: WIDTH];
   assign Q_n = ~Q;

   always_ff @(posedge main_clk or negedge R_n) begin
      if (!R_n)          OVL <= 1'b0;
      else if (C1 && C2) OVL <= 1'b1;
   end

endmodule

// File: tb/tb_nmos_dff_shreg.sv
// Directed bench for nmos_dff_shreg (WIDTH=4, DEPTH=3, DECAY_CYC=8, DECAY_VAL=1).
// The driver queues hand-computed expectations; a negedge monitor pops and compares them.
module tb_nmos_dff_shreg;

   localparam int W  = 4;
   localparam int N  = 3;
   localparam int EW = W * N + W + W + N + 1;

   logic           main_clk;
   logic           R_n;
   logic           C1, C2, SH, LD;
   logic [W-1:0]   D;
   logic [W*N-1:0] P;
   logic [W-1:0]   Q, Q_n;
   logic [W*N-1:0] PQ;
   logic [N-1:0]   STALE;
   logic           OVL;

   logic [EW-1:0] exp_q[$];
   string         name_q[$];
   int            checks;
   int            passes;
   bit            driver_done;

   nmos_dff_shreg #(
      .WIDTH     (W),
      .DEPTH     (N),
      .DECAY_CYC (8),
      .DECAY_VAL (1'b1)
   ) dut (
      .main_clk (main_clk),
      .R_n      (R_n),
      .C1       (C1),
      .C2       (C2),
      .SH       (SH),
      .LD       (LD),
      .D        (D),
      .P        (P),
      .Q        (Q),
      .Q_n      (Q_n),
      .PQ       (PQ),
      .STALE    (STALE),
      .OVL      (OVL)
   );

   // clock / reset
   initial begin
      main_clk = 1'b0;
      forever #5 main_clk = ~main_clk;
   end

   // driver tasks
   task automatic step(input logic c1_i, input logic c2_i, input logic sh_i,
                       input logic ld_i, input logic [W-1:0] d_i,
                       input logic [W*N-1:0] p_i);
      C1 = c1_i; C2 = c2_i; SH = sh_i; LD = ld_i; D = d_i; P = p_i;
      @(posedge main_clk);
      #1;
      C1 = 1'b0; C2 = 1'b0; SH = 1'b0; LD = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
   endtask

   task automatic shift_pair(input logic [W-1:0] d_i);
      step(1'b0, 1'b1, 1'b1, 1'b0, d_i, '0);
      step(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
   endtask

   task automatic expect_out(input string name, input logic [W*N-1:0] pq,
                             input logic [N-1:0] stale, input logic ovl);
      logic [W-1:0] q;
      q = pq[W*N-1 -: W];
      exp_q.push_back({pq, q, ~q, stale, ovl});
      name_q.push_back(name);
   endtask

   // scoreboard monitor
   always @(negedge main_clk) begin
      while (exp_q.size() > 0) begin
         logic [EW-1:0] e;
         logic [EW-1:0] a;
         string         nm;
         e  = exp_q.pop_front();
         nm = name_q.pop_front();
         a  = {PQ, Q, Q_n, STALE, OVL};
         checks++;
         if (a === e) passes++;
         else $display("FAIL %s: got pq=%h q=%h qn=%h stale=%b ovl=%b, want pq=%h q=%h qn=%h stale=%b ovl=%b",
                       nm, a[EW-1 -: W*N], a[EW-W*N-1 -: W], a[EW-W*N-W-1 -: W], a[N:1], a[0],
                       e[EW-1 -: W*N], e[EW-W*N-1 -: W], e[EW-W*N-W-1 -: W], e[N:1], e[0]);
      end
   end

   // stimulus
   initial begin
      checks = 0; passes = 0; driver_done = 1'b0;
      R_n = 1'b0; C1 = 1'b0; C2 = 1'b0; SH = 1'b0; LD = 1'b0; D = '0; P = '0;
      repeat (2) @(posedge main_clk);
      #1;
      expect_out("reset", 12'h000, 3'b000, 1'b0);
      @(posedge main_clk);
      #1;
      R_n = 1'b1;

      // serial shift A,5,3
      shift_pair(4'hA);
      expect_out("shift1", 12'h00A, 3'b000, 1'b0);
      shift_pair(4'h5);
      expect_out("shift2", 12'h0A5, 3'b000, 1'b0);
      step(1'b0, 1'b1, 1'b1, 1'b0, 4'h3, '0);
      expect_out("c2_only", 12'h0A5, 3'b000, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
      expect_out("shift3", 12'hA53, 3'b000, 1'b0);

      // LD beats SH, then hold with no phases
      step(1'b0, 1'b1, 1'b1, 1'b1, 4'hF, 12'h123);
      step(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
      expect_out("ld_wins", 12'h123, 3'b000, 1'b0);
      idle(2);
      expect_out("hold", 12'h123, 3'b000, 1'b0);

      // refresh every 4 edges keeps contents and no decay
      for (int r = 0; r < 4; r++) begin
         step(1'b0, 1'b1, 1'b0, 1'b0, '0, '0);
         step(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
         idle(2);
      end
      expect_out("recirc", 12'h123, 3'b000, 1'b0);

      // decay after 8 edges without C1
      step(1'b0, 1'b1, 1'b0, 1'b1, '0, 12'h000);
      step(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
      expect_out("load0", 12'h000, 3'b000, 1'b0);
      idle(7);
      expect_out("pre_decay", 12'h000, 3'b000, 1'b0);
      idle(1);
      expect_out("decay", 12'hFFF, 3'b111, 1'b0);
      shift_pair(4'h0);
      step(1'b0, 1'b1, 1'b0, 1'b0, '0, '0);
      step(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
      expect_out("refresh", 12'hFF0, 3'b000, 1'b0);

      // overlapping phases: masters 5, slaves 3
      step(1'b0, 1'b1, 1'b0, 1'b1, '0, 12'h333);
      step(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
      step(1'b0, 1'b1, 1'b0, 1'b1, '0, 12'h555);
      step(1'b1, 1'b1, 1'b1, 1'b0, 4'h7, '0);
      expect_out("ovl_edge", 12'h555, 3'b000, 1'b1);
      step(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
      expect_out("ovl_next", 12'h337, 3'b000, 1'b1);
      idle(100);
      expect_out("ovl_hold", 12'hFFF, 3'b111, 1'b1);

      // async reset between edges mid-shift
      step(1'b0, 1'b1, 1'b0, 1'b1, '0, 12'h9C6);
      step(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
      step(1'b0, 1'b1, 1'b1, 1'b0, 4'h9, '0);
      #1;
      R_n = 1'b0;
      #1;
      expect_out("async_rst", 12'h000, 3'b000, 1'b0);
      @(posedge main_clk);
      #1;
      R_n = 1'b1;
      shift_pair(4'hA);
      shift_pair(4'h5);
      shift_pair(4'h3);
      expect_out("post_rst_shift", 12'hA53, 3'b000, 1'b0);
      driver_done = 1'b1;
   end

   // final report
   initial begin
      int budget;
      budget = 0;
      while (!driver_done && budget < 5000) begin
         @(posedge main_clk);
         budget++;
      end
      repeat (2) @(posedge main_clk);
      if (!driver_done || exp_q.size() != 0) begin
         checks++;
         $display("FAIL drain: driver_done=%0d pending=%0d, want driver_done=1 pending=0",
                  driver_done, exp_q.size());
      end
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
